// File: rtl/power_window_acc_pkg.sv
// Shared types and helpers for the power window accumulator.
// FSM encoding and accumulator width derivation live here.
package power_window_acc_pkg;

    // Window FSM: IDLE means no sample of the current window yet.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } win_state_t;

    localparam int IN_WIDTH_DEF = 64;

    // Width that holds win_len samples of in_w bits without overflow.
    function automatic int acc_width(input int in_w, input int win_len);
        return in_w + $clog2(win_len);
    endfunction

endpackage

// File: rtl/power_window_acc.sv
// Window energy accumulator: sums WIN_LEN power samples and tracks the peak.
// Emits a one-cycle result pulse per completed window; i_clear aborts a window.
module power_window_acc
    import power_window_acc_pkg::*;
#(
    parameter int IN_WIDTH   = IN_WIDTH_DEF,
    parameter int WIN_LEN    = 4,
    parameter int CNT_WIDTH  = 16,
    localparam int ACC_WIDTH = acc_width(IN_WIDTH, WIN_LEN)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_valid,
    input  logic [IN_WIDTH-1:0]  i_data,
    input  logic                 i_clear,
    output logic                 o_valid,
    output logic [ACC_WIDTH-1:0] o_sum,
    output logic [IN_WIDTH-1:0]  o_max,
    output logic [CNT_WIDTH-1:0] o_win_cnt,
    output logic                 o_busy
);

    localparam int SC_WIDTH = $clog2(WIN_LEN + 1);
    localparam logic [SC_WIDTH-1:0] LAST_IDX = SC_WIDTH'(WIN_LEN - 1);

    win_state_t            r_state;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [IN_WIDTH-1:0]   r_max;
    logic [SC_WIDTH-1:0]   r_cnt;
    logic                  r_valid;
    logic [ACC_WIDTH-1:0]  r_sum;
    logic [IN_WIDTH-1:0]   r_peak;
    logic [CNT_WIDTH-1:0]  r_win_cnt;

    logic                  w_accept;
    logic                  w_last;
    logic [ACC_WIDTH-1:0]  w_data_ext;
    logic [ACC_WIDTH-1:0]  w_acc_next;
    logic [IN_WIDTH-1:0]   w_max_next;

    // Datapath: running sum and running peak including the current sample.
    always_comb begin
        w_accept   = i_valid && !i_clear;
        w_last     = (r_cnt == LAST_IDX);
        w_data_ext = {{(ACC_WIDTH - IN_WIDTH){1'b0}}, i_data};
        w_acc_next = r_acc + w_data_ext;
        w_max_next = (i_data > r_max) ? i_data : r_max;
    end

    // Control FSM with registered window results; clear beats sample accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_max     <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_sum     <= '0;
            r_peak    <= '0;
            r_win_cnt <= '0;
        end else begin
            r_valid <= 1'b0;
            if (i_clear) begin
                r_state <= ST_IDLE;
                r_acc   <= '0;
                r_max   <= '0;
                r_cnt   <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_sum     <= w_acc_next;
                    r_peak    <= w_max_next;
                    r_valid   <= 1'b1;
                    r_win_cnt <= r_win_cnt + 1'b1;
                    r_state   <= ST_IDLE;
                    r_acc     <= '0;
                    r_max     <= '0;
                    r_cnt     <= '0;
                end else begin
                    r_state <= ST_FILL;
                    r_acc   <= w_acc_next;
                    r_max   <= w_max_next;
                    r_cnt   <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_sum     = r_sum;
    assign o_max     = r_peak;
    assign o_win_cnt = r_win_cnt;
    assign o_busy    = (r_state == ST_FILL);

endmodule
